// File: rtl/sd_cmd_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sd_cmd_arbiter_if : host/BD request, command-master and report bus |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface sd_cmd_arbiter_if #(
    parameter int TW = 16
);
    logic          write_req_s;
    logic [15:0]   cmd_set_s;
    logic [31:0]   cmd_arg_s;
    logic          bd_req_i;
    logic [15:0]   bd_cmd_set_i;
    logic [31:0]   bd_cmd_arg_i;
    logic [TW-1:0] timeout_i;
    logic          cmd_done_i;
    logic          cmd_err_i;
    logic          cmd_start_o;
    logic [15:0]   cmd_set_o;
    logic [31:0]   cmd_arg_o;
    logic          done_o;
    logic          err_o;
    logic          tout_o;
    logic          owner_o;
    logic          bd_ack_o;
    logic          host_busy_o;
    logic          host_ovf_o;

    modport slave (
        input  write_req_s, cmd_set_s, cmd_arg_s,
        input  bd_req_i, bd_cmd_set_i, bd_cmd_arg_i,
        input  timeout_i, cmd_done_i, cmd_err_i,
        output cmd_start_o, cmd_set_o, cmd_arg_o,
        output done_o, err_o, tout_o, owner_o,
        output bd_ack_o, host_busy_o, host_ovf_o
    );

    modport master (
        output write_req_s, cmd_set_s, cmd_arg_s,
        output bd_req_i, bd_cmd_set_i, bd_cmd_arg_i,
        output timeout_i, cmd_done_i, cmd_err_i,
        input  cmd_start_o, cmd_set_o, cmd_arg_o,
        input  done_o, err_o, tout_o, owner_o,
        input  bd_ack_o, host_busy_o, host_ovf_o
    );
endinterface
`default_nettype wire

// File: rtl/sd_cmd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sd_cmd_arbiter : round-robin host/BD command arbiter with timeout  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sd_cmd_arbiter #(
    parameter int TW = 16
) (
    input  wire logic       wb_clk_i,
    input  wire logic       wb_rst_n_i,
    sd_cmd_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [TW-1:0] CNT_ONE = TW'(1);

    state_t        state;
    logic          host_full;
    logic [15:0]   host_set;
    logic [31:0]   host_arg;
    logic          bd_pend;
    logic          bd_mask;
    logic          last_bd;
    logic [TW-1:0] cnt;

    logic          cmd_start;
    logic [15:0]   cmd_set;
    logic [31:0]   cmd_arg;
    logic          done;
    logic          err;
    logic          tout;
    logic          owner;
    logic          bd_ack;
    logic          host_ovf;

    logic host_active;
    logic host_accept;
    logic bd_req_eff;
    logic grant_host;
    logic grant_bd;
    logic tout_hit;

    // A host-owned DONE frees the slot this cycle, so a new write is taken.
    assign host_active = !owner && (state != ST_IDLE);
    assign host_accept = bus.write_req_s &&
                         ((!host_full && !host_active) ||
                          (state == ST_DONE && !owner));

    // BD level is sampled so both requesters see the same one-edge latency.
    assign bd_req_eff  = bd_pend && !bd_mask;
    assign grant_host  = host_full && (!bd_req_eff || last_bd);
    assign grant_bd    = bd_req_eff && (!host_full || !last_bd);
    assign tout_hit    = (bus.timeout_i != '0) && (cnt == bus.timeout_i - CNT_ONE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state     <= ST_IDLE;
            host_full <= 1'b0;
            host_set  <= '0;
            host_arg  <= '0;
            bd_pend   <= 1'b0;
            bd_mask   <= 1'b0;
            last_bd   <= 1'b1;
            cnt       <= '0;
            cmd_start <= 1'b0;
            cmd_set   <= '0;
            cmd_arg   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            tout      <= 1'b0;
            owner     <= 1'b0;
            bd_ack    <= 1'b0;
            host_ovf  <= 1'b0;
        end else begin
            bd_pend   <= bus.bd_req_i;
            bd_mask   <= bd_ack;
            host_ovf  <= bus.write_req_s && !host_accept;
            cmd_start <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            tout      <= 1'b0;
            bd_ack    <= 1'b0;

            if (host_accept) begin
                host_full <= 1'b1;
                host_set  <= bus.cmd_set_s;
                host_arg  <= bus.cmd_arg_s;
            end else if (state == ST_DONE && !owner) begin
                host_full <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (grant_host) begin
                        state     <= ST_ISSUE;
                        cmd_start <= 1'b1;
                        cmd_set   <= host_set;
                        cmd_arg   <= host_arg;
                        owner     <= 1'b0;
                        last_bd   <= 1'b0;
                    end else if (grant_bd) begin
                        state     <= ST_ISSUE;
                        cmd_start <= 1'b1;
                        cmd_set   <= bus.bd_cmd_set_i;
                        cmd_arg   <= bus.bd_cmd_arg_i;
                        owner     <= 1'b1;
                        last_bd   <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                    cnt   <= '0;
                end
                ST_WAIT: begin
                    if (bus.cmd_done_i) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        err    <= bus.cmd_err_i;
                        bd_ack <= owner;
                    end else if (tout_hit) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        tout   <= 1'b1;
                        bd_ack <= owner;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_start_o = cmd_start;
    assign bus.cmd_set_o   = cmd_set;
    assign bus.cmd_arg_o   = cmd_arg;
    assign bus.done_o      = done;
    assign bus.err_o       = err;
    assign bus.tout_o      = tout;
    assign bus.owner_o     = owner;
    assign bus.bd_ack_o    = bd_ack;
    assign bus.host_busy_o = host_full || host_active;
    assign bus.host_ovf_o  = host_ovf;
endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sd_cmd_arbiter : directed self-checking bench for the arbiter   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_sd_cmd_arbiter;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    sd_cmd_arbiter_if #(.TW(16)) bus ();

    sd_cmd_arbiter #(.TW(16)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input bit ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [15:0] s, input logic [31:0] a);
        bus.write_req_s = 1'b1;
        bus.cmd_set_s   = s;
        bus.cmd_arg_s   = a;
        step();
        bus.write_req_s = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!bus.cmd_start_o && n < 100) begin
            step();
            n++;
        end
        check("start_seen", bus.cmd_start_o === 1'b1);
    endtask

    // Called in the ISSUE cycle; returns in the DONE cycle.
    task automatic finish_cmd(input logic e);
        step();
        bus.cmd_done_i = 1'b1;
        bus.cmd_err_i  = e;
        step();
        bus.cmd_done_i = 1'b0;
        bus.cmd_err_i  = 1'b0;
    endtask

    task automatic tie_round(input string tag);
        int n;
        int s;
        bus.bd_req_i = 1'b1;
        host_write(16'h0033, 32'h0000_0400);
        wait_start(n);
        check({tag, "_first_owner"}, bus.owner_o === 1'b0);
        check({tag, "_first_set"}, bus.cmd_set_o === 16'h0033);
        finish_cmd(1'b0);
        check({tag, "_first_done"}, bus.done_o === 1'b1);
        wait_start(n);
        check({tag, "_second_owner"}, bus.owner_o === 1'b1);
        check({tag, "_second_set"}, bus.cmd_set_o === 16'h0022);
        check({tag, "_second_arg"}, bus.cmd_arg_o === 32'h0000_0300);
        finish_cmd(1'b0);
        check({tag, "_bd_ack"}, bus.bd_ack_o === 1'b1);
        step();
        bus.bd_req_i = 1'b0;
        s = 0;
        repeat (3) begin
            step();
            s += int'(bus.cmd_start_o);
        end
        check({tag, "_mask_no_regrant"}, s == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int hi;
        rst_n            = 1'b0;
        bus.write_req_s  = 1'b0;
        bus.cmd_set_s    = '0;
        bus.cmd_arg_s    = '0;
        bus.bd_req_i     = 1'b0;
        bus.bd_cmd_set_i = 16'h0022;
        bus.bd_cmd_arg_i = 32'h0000_0300;
        bus.timeout_i    = '0;
        bus.cmd_done_i   = 1'b0;
        bus.cmd_err_i    = 1'b0;
        step();
        step();
        check("rst_start", bus.cmd_start_o === 1'b0);
        check("rst_done", bus.done_o === 1'b0);
        check("rst_owner", bus.owner_o === 1'b0);
        check("rst_busy", bus.host_busy_o === 1'b0);
        check("rst_set", bus.cmd_set_o === 16'h0000);
        check("rst_ack", bus.bd_ack_o === 1'b0);
        rst_n = 1'b1;
        step();

        // Host-only command with fixed latency
        host_write(16'h0011, 32'h0000_0200);
        check("host_busy_pending", bus.host_busy_o === 1'b1);
        check("host_no_early_start", bus.cmd_start_o === 1'b0);
        wait_start(n);
        check("host_latency", n == 1);
        check("host_set", bus.cmd_set_o === 16'h0011);
        check("host_arg", bus.cmd_arg_o === 32'h0000_0200);
        check("host_owner_issue", bus.owner_o === 1'b0);
        step();
        check("host_start_one_cycle", bus.cmd_start_o === 1'b0);
        repeat (3) step();
        bus.cmd_done_i = 1'b1;
        step();
        bus.cmd_done_i = 1'b0;
        check("host_done", bus.done_o === 1'b1);
        check("host_done_owner", bus.owner_o === 1'b0);
        check("host_done_err", bus.err_o === 1'b0);
        check("host_done_tout", bus.tout_o === 1'b0);
        check("host_busy_done", bus.host_busy_o === 1'b1);
        step();
        check("host_done_pulse", bus.done_o === 1'b0);
        check("host_busy_clear", bus.host_busy_o === 1'b0);

        // Round-robin ties straight after reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        tie_round("tie1");
        tie_round("tie2");

        // Timeout of 8: exactly 8 WAIT cycles then DONE
        bus.timeout_i = 16'd8;
        host_write(16'h0012, 32'h0000_0012);
        wait_start(n);
        hi = 0;
        repeat (8) begin
            step();
            hi += int'(bus.done_o);
        end
        check("tout8_no_early_done", hi == 0);
        step();
        check("tout8_done", bus.done_o === 1'b1);
        check("tout8_flag", bus.tout_o === 1'b1);
        check("tout8_err", bus.err_o === 1'b0);
        step();

        // Timeout disabled, then a live change of the limit
        bus.timeout_i = '0;
        host_write(16'h0013, 32'h0000_0013);
        wait_start(n);
        hi = 0;
        repeat (40) begin
            step();
            hi += int'(bus.done_o);
        end
        check("tout0_waits", hi == 0);
        bus.timeout_i = 16'd41;
        step();
        check("tout_live_not_yet", bus.done_o === 1'b0);
        step();
        check("tout_live_done", bus.done_o === 1'b1);
        check("tout_live_flag", bus.tout_o === 1'b1);
        bus.timeout_i = '0;
        step();

        // Done coincident with timeout: done wins, err follows cmd_err_i
        for (int e = 0; e < 2; e++) begin
            bus.timeout_i = 16'd4;
            host_write(16'h0014, 32'h0000_0014);
            wait_start(n);
            repeat (4) step();
            bus.cmd_done_i = 1'b1;
            bus.cmd_err_i  = e[0];
            step();
            bus.cmd_done_i = 1'b0;
            bus.cmd_err_i  = 1'b0;
            check("both_done", bus.done_o === 1'b1);
            check("both_tout", bus.tout_o === 1'b0);
            check("both_err", bus.err_o === e[0]);
            step();
        end
        bus.timeout_i = '0;

        // Overflow during WAIT, acceptance on the host DONE cycle
        host_write(16'h0044, 32'h0000_0440);
        wait_start(n);
        step();
        host_write(16'h0055, 32'h0000_0550);
        check("ovf_pulse", bus.host_ovf_o === 1'b1);
        check("ovf_set_kept", bus.cmd_set_o === 16'h0044);
        step();
        check("ovf_one_cycle", bus.host_ovf_o === 1'b0);
        bus.cmd_done_i = 1'b1;
        step();
        bus.cmd_done_i = 1'b0;
        check("ovf_done", bus.done_o === 1'b1);
        host_write(16'h0066, 32'h0000_0660);
        check("done_accept_no_ovf", bus.host_ovf_o === 1'b0);
        check("done_accept_busy", bus.host_busy_o === 1'b1);
        wait_start(n);
        check("reissue_set", bus.cmd_set_o === 16'h0066);
        check("reissue_arg", bus.cmd_arg_o === 32'h0000_0660);
        finish_cmd(1'b0);
        step();

        // Reset during a BD-owned WAIT, then regrant of the held request
        bus.bd_cmd_set_i = 16'h0077;
        bus.bd_cmd_arg_i = 32'h0000_0770;
        bus.bd_req_i     = 1'b1;
        wait_start(n);
        check("bd_owner", bus.owner_o === 1'b1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("rstw_owner", bus.owner_o === 1'b0);
        check("rstw_set", bus.cmd_set_o === 16'h0000);
        check("rstw_start", bus.cmd_start_o === 1'b0);
        step();
        check("rstw_no_ack", bus.bd_ack_o === 1'b0);
        check("rstw_no_done", bus.done_o === 1'b0);
        rst_n = 1'b1;
        wait_start(n);
        check("regrant_owner", bus.owner_o === 1'b1);
        check("regrant_set", bus.cmd_set_o === 16'h0077);
        finish_cmd(1'b0);
        check("regrant_ack", bus.bd_ack_o === 1'b1);
        step();
        bus.bd_req_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sd_cmd_arbiter.md
SD_CMD_ARBITER -- requirements
Module: sd_cmd_arbiter

Interface
REQ-001 SHALL have parameter TW, default 16, timeout counter/compare width.
REQ-002 SHALL have port wb_clk_i  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port wb_rst_n_i  in  1  asynchronous active-low reset.
REQ-004 SHALL have port write_req_s  in  1  host command request pulse from register block.
REQ-005 SHALL have ports cmd_set_s  in  16 and cmd_arg_s  in  32  host command word and argument, valid with write_req_s.
REQ-006 SHALL have port bd_req_i  in  1  buffer-descriptor engine request, level, held until bd_ack_o.
REQ-007 SHALL have ports bd_cmd_set_i  in  16 and bd_cmd_arg_i  in  32  BD command, stable while bd_req_i high.
REQ-008 SHALL have port timeout_i  in  TW  WAIT-state cycle limit, 0 disables.
REQ-009 SHALL have ports cmd_done_i  in  1 and cmd_err_i  in  1  completion pulse and error from command master, err valid with done.
REQ-010 SHALL have ports cmd_start_o  out  1, cmd_set_o  out  16, cmd_arg_o  out  32  one-cycle issue strobe and held command.
REQ-011 SHALL have ports done_o  out  1, err_o  out  1, tout_o  out  1, owner_o  out  1 (0 host, 1 BD)  completion report.
REQ-012 SHALL have ports bd_ack_o  out  1, host_busy_o  out  1, host_ovf_o  out  1.

Function
REQ-013 SHALL latch cmd_set_s/cmd_arg_s into a host pending slot on write_req_s when slot empty and host not owner of an active command.
REQ-014 SHALL drop write_req_s arriving while host slot full or host command active, pulsing host_ovf_o one cycle later; slot contents unchanged.
REQ-015 SHALL accept write_req_s in the same cycle as host-owned DONE (set wins over clear).
REQ-016 SHALL drive host_busy_o = host slot full OR host-owned command in ISSUE/WAIT/DONE.
REQ-017 SHALL implement FSM IDLE, ISSUE, WAIT, DONE, all registered.
REQ-018 IDLE: no request -> stay; one request -> ISSUE granting it; both -> ISSUE granting requester not served last (round-robin), capture set/arg/owner.
REQ-019 SHALL mask bd_req_i in IDLE for the one cycle following bd_ack_o.
REQ-020 ISSUE: cmd_start_o = 1 for exactly this cycle; cmd_done_i ignored; -> WAIT, timeout counter cleared to 0.
REQ-021 WAIT: cmd_done_i -> DONE with err_o = cmd_err_i; else if timeout_i != 0 and counter == timeout_i-1 -> DONE with tout_o = 1; else counter +1, no wrap (saturate).
REQ-022 Simultaneous cmd_done_i and timeout SHALL resolve as done (tout_o = 0).
REQ-023 timeout_i SHALL be compared live each WAIT cycle.
REQ-024 DONE: done_o = 1 one cycle with err_o/tout_o/owner_o valid; host owner clears slot; BD owner pulses bd_ack_o; -> IDLE.
REQ-025 cmd_set_o/cmd_arg_o/owner_o SHALL hold from ISSUE until next grant.
REQ-026 Grant-to-start latency SHALL be: write_req_s sampled at edge N, idle FSM -> cmd_start_o high in cycle after edge N+1.

Reset
REQ-027 wb_rst_n_i low SHALL immediately force IDLE, clear pending slot, counter, mask, all outputs to 0, last-served = BD (host wins first tie).
REQ-028 Reset mid-ISSUE/WAIT SHALL abandon the command without done_o or bd_ack_o.

Verification
REQ-029 Host only: write_req_s with set 16'h0011, arg 32'h0000_0200 -> cmd_start_o 2 edges later with same values; cmd_done_i after 5 -> done_o, owner_o 0, err_o 0.
REQ-030 Tie: write_req_s and bd_req_i same cycle after reset -> host granted first, then BD; third tie repeats alternation host, BD.
REQ-031 Timeout: timeout_i = 8, no cmd_done_i -> done_o with tout_o = 1 exactly 8 WAIT cycles after ISSUE; timeout_i = 0 -> waits indefinitely.
REQ-032 Overflow: second write_req_s during host WAIT -> host_ovf_o pulse, cmd_set_o unchanged; write_req_s on host DONE cycle -> accepted, reissued.
REQ-033 Done plus timeout same cycle -> tout_o = 0, err_o = cmd_err_i; cmd_err_i = 1 -> err_o = 1.
REQ-034 Reset asserted in WAIT with BD owner -> outputs 0, no bd_ack_o; after release held bd_req_i regranted.
